// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice.
// Holds the opcode encodings, the issue-stage FSM state type, the flag
// bit positions and the packed flag payload captured from the ALU.
package alu_pkg;

    localparam int unsigned FLAGS_W = 4;

    // Opcode encodings understood by the ALU; 3'b100..3'b111 raise error.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    // Flag bit positions inside flags_q.
    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_O = 2;
    localparam int unsigned FLG_E = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Flag payload, MSB first: {error, overflow, carry, zero}.
    typedef struct packed {
        logic error;
        logic overflow;
        logic carry;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file for the issue stage.
// Ports: clk/rst_n (async active-low, clears all entries), one write port
// (we/waddr/wdata), three combinational read ports: two operand reads
// (raddr1/rdata1, raddr2/rdata2) and a debug read (raddr3/rdata3).
module alu_regfile #(
    parameter  int unsigned DATA_W = 2,
    parameter  int unsigned NREGS  = 4,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [AW-1:0]     raddr3,
    output logic [DATA_W-1:0] rdata3
);

    logic [DATA_W-1:0] rf [NREGS];

    // Storage with single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    // Combinational reads.
    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];
    assign rdata3 = rf[raddr3];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage wrapped around the combinational 2-bit ALU.
// Accepts register-addressed instructions (instr_*), direct register loads
// (ld_*), drives registered operands/opcode to the ALU (alu_a/alu_b/alu_sel),
// captures the ALU result and flags (alu_out/alu_zero/alu_carry/
// alu_overflow/alu_error -> result_q/flags_q), writes the result back,
// pulses done on retire and keeps err_sticky (cleared by clr_err).
// dbg_addr/dbg_data give a combinational register read.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter  int unsigned DATA_W = 2,
    parameter  int unsigned NREGS  = 4,
    parameter  int unsigned SEL_W  = 3,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [SEL_W-1:0]   instr_op,
    input  logic [AW-1:0]      instr_rd,
    input  logic [AW-1:0]      instr_rs1,
    input  logic [AW-1:0]      instr_rs2,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [AW-1:0]      ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    input  logic               alu_error,
    output logic [DATA_W-1:0]  result_q,
    output logic [FLAGS_W-1:0] flags_q,
    output logic               done,
    output logic               err_sticky,
    input  logic               clr_err,
    input  logic [AW-1:0]      dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              ld_wr;
    logic              wb_wr;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [AW-1:0]     rd_q;
    flags_t            flags_cap;

    // Load and writeback never overlap: loads only in IDLE, writeback only in WB.
    assign rf_we    = ld_wr | wb_wr;
    assign rf_waddr = wb_wr ? rd_q : ld_addr;
    assign rf_wdata = wb_wr ? result_q : ld_data;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (instr_rs1),
        .rdata1 (rs1_data),
        .raddr2 (instr_rs2),
        .rdata2 (rs2_data),
        .raddr3 (dbg_addr),
        .rdata3 (dbg_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/control decode; a load wins over an instruction.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        ld_ready    = 1'b0;
        accept      = 1'b0;
        ld_wr       = 1'b0;
        wb_wr       = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                ld_ready    = 1'b1;
                instr_ready = !ld_valid;
                ld_wr       = ld_valid;
                if (instr_valid && !ld_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = WB;
            end
            WB: begin
                done       = 1'b1;
                wb_wr      = !flags_q[FLG_E];
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign flags_cap = '{error:    alu_error,
                         overflow: alu_overflow,
                         carry:    alu_carry,
                         zero:     alu_zero};

    // Operand issue and result capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            rd_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (accept) begin
                alu_a   <= rs1_data;
                alu_b   <= rs2_data;
                alu_sel <= instr_op;
                rd_q    <= instr_rd;
            end
            if (state == EXEC) begin
                result_q <= alu_out;
                flags_q  <= flags_cap;
            end
        end
    end

    // Sticky error: a new error in EXEC takes precedence over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if ((state == EXEC) && alu_error) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

endmodule
